// File: rtl/uart_mul_frame_pkg.sv
// Shared types and defaults for the UART multiplier framing stage.
package mul_uart_pkg;

   localparam int DATA_W = 8;
   localparam int RES_W  = 2 * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_B,
      S_MUL,
      S_SEND_HI,
      S_WAIT_HI,
      S_SEND_LO,
      S_WAIT_LO
   } state_t;

   // Every state that cannot accept a new received byte.
   function automatic logic is_busy(state_t s);
      return !((s == S_IDLE) || (s == S_GET_B));
   endfunction

endpackage

// File: rtl/uart_mul_frame_if.sv
// Byte-level bus between the UART RX/TX and the multiplier framing stage.
interface uart_mul_frame_if #(
   parameter int DATA_W = mul_uart_pkg::DATA_W
);
   localparam int RES_W = 2 * DATA_W;

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic [RES_W-1:0]  result;
   logic              result_valid;
   logic              busy;
   logic              overrun;
   logic              timeout;

   // Framing stage side.
   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_start, result, result_valid, busy, overrun, timeout
   );

   // Environment side (UART RX/TX).
   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_start, result, result_valid, busy, overrun, timeout
   );

endinterface

// File: rtl/uart_mul_frame_seq_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per clock, LSB first.
// done pulses for one cycle once the last partial product has been added.
module seq_mul #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   localparam int RES_W = 2 * DATA_W;
   localparam int CW    = $clog2(DATA_W + 1);

   logic [RES_W-1:0]  mcand_q;
   logic [DATA_W-1:0] mplier_q;
   logic [RES_W-1:0]  acc_q;
   logic [CW-1:0]     cnt_q;
   logic              done_q;

   // Load operands on start, then add/shift once per cycle until cnt hits 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{DATA_W{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CW'(DATA_W);
         done_q   <= 1'b0;
      end else if (cnt_q != '0) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
         done_q   <= (cnt_q == CW'(1));
      end else begin
         done_q   <= 1'b0;
      end
   end

   assign done    = done_q;
   assign product = acc_q;

endmodule

// File: rtl/uart_mul_frame.sv
// Operand framing, timeout, and two-byte TX handshake around seq_mul.
// All outputs come straight from flops.
module uart_mul_frame #(
   parameter int DATA_W      = mul_uart_pkg::DATA_W,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic        clk,
   input  logic        reset,
   uart_mul_frame_if.slave bus
);
   import mul_uart_pkg::*;

   localparam int RES_W = 2 * DATA_W;
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [RES_W-1:0]  result_q;
   logic [DATA_W-1:0] tx_data_q;
   logic              tx_start_q, rv_q, busy_q, ov_q, to_q;

   logic a_ld, cnt_clr, cnt_inc, mul_start, res_ld, ld_hi, ld_lo;
   logic ts_d, rv_d, ov_d, to_d;
   logic mul_done;
   logic [RES_W-1:0] mul_product;

   seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (a_q),
      .b       (bus.rx_data),
      .done    (mul_done),
      .product (mul_product)
   );

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d   = state_q;
      a_ld      = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      mul_start = 1'b0;
      res_ld    = 1'b0;
      ld_hi     = 1'b0;
      ld_lo     = 1'b0;
      ts_d      = 1'b0;
      rv_d      = 1'b0;
      to_d      = 1'b0;
      // A byte arriving while busy is dropped; the frame in flight is untouched.
      ov_d      = bus.rx_valid && is_busy(state_q);
      case (state_q)
         S_IDLE: if (bus.rx_valid) begin
            a_ld    = 1'b1;
            cnt_clr = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            // A byte on the expiry cycle still wins over the timeout.
            if (bus.rx_valid) begin
               mul_start = 1'b1;
               state_d   = S_MUL;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               to_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_MUL: if (mul_done) begin
            res_ld  = 1'b1;
            rv_d    = 1'b1;
            state_d = S_SEND_HI;
         end
         S_SEND_HI: if (bus.tx_ready) begin
            ld_hi   = 1'b1;
            ts_d    = 1'b1;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: if (!bus.tx_ready) state_d = S_SEND_LO;
         S_SEND_LO: if (bus.tx_ready) begin
            ld_lo   = 1'b1;
            ts_d    = 1'b1;
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: if (!bus.tx_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, operand, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         rv_q       <= 1'b0;
         busy_q     <= 1'b0;
         ov_q       <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (a_ld)    a_q   <= bus.rx_data;
         if (cnt_clr) cnt_q <= '0;
         else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
         if (res_ld)  result_q <= mul_product;
         if (ld_hi)   tx_data_q <= result_q[RES_W-1:DATA_W];
         else if (ld_lo) tx_data_q <= result_q[DATA_W-1:0];
         tx_start_q <= ts_d;
         rv_q       <= rv_d;
         busy_q     <= is_busy(state_d);
         ov_q       <= ov_d;
         to_q       <= to_d;
      end
   end

   assign bus.tx_data      = tx_data_q;
   assign bus.tx_start     = tx_start_q;
   assign bus.result       = result_q;
   assign bus.result_valid = rv_q;
   assign bus.busy         = busy_q;
   assign bus.overrun      = ov_q;
   assign bus.timeout      = to_q;

endmodule
